// File: rtl/nibble_operand_loader_if.sv
// rtl/nibble_operand_loader_if.sv - operand pair handshake towards the nibble adder
//
// Purpose: carries the packed operand pair and its valid/ready handshake.
// Signals:
//   op_valid  loader -> adder   op_byte holds a complete pair
//   op_ready  adder  -> loader  adder accepts the pair this cycle
//   op_byte   loader -> adder   {A, B}, A entered first
// Modports: master = loader side, slave = adder side.
interface nibble_operand_loader_if #(
  parameter int NIBBLE_W = 4
);
  logic                  op_valid;
  logic                  op_ready;
  logic [2*NIBBLE_W-1:0] op_byte;

  modport master (
    output op_valid,
    output op_byte,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_byte,
    output op_ready
  );
endinterface

// File: rtl/nibble_operand_loader.sv
// rtl/nibble_operand_loader.sv - builds an {A,B} nibble pair from strobed pad entries
//
// Purpose: synchronises a slow asynchronous strobe, captures two successive
// nibbles as an operand pair and offers it over a valid/ready handshake.
// Entries arriving while no storage is free are dropped and flagged.
// Optional feature macro: LOADER_SKID_EN adds a skid pair register behind the
// output register so a second pair can be assembled while the first waits.
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset (clears everything incl. sync flops)
//   load_strobe   asynchronous strobe; each rising edge enters one nibble
//   data_in       nibble sampled on the detected edge
//   clear         synchronous soft clear (below reset, above everything else)
//   op_if         master side of the pair handshake (op_valid/op_ready/op_byte)
//   have_a        A captured, waiting for B
//   overflow_err  sticky: an entry was dropped
module nibble_operand_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int NIBBLE_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_strobe,
  input  logic [NIBBLE_W-1:0]     data_in,
  input  logic                    clear,
  nibble_operand_loader_if.master op_if,
  output logic                    have_a,
  output logic                    overflow_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  sync_dly_q;
  logic                  ent;
  logic [NIBBLE_W-1:0]   a_q, a_d;
  logic [2*NIBBLE_W-1:0] byte_q, byte_d;
  logic                  ovf_q, ovf_d;

`ifdef LOADER_SKID_EN
  // Skid fill level: 0 empty, 1 holds A, 2 holds a complete pair.
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic [NIBBLE_W-1:0]   skid_a_q, skid_a_d;
  logic [NIBBLE_W-1:0]   skid_b_q, skid_b_d;
`endif

  // One-cycle pulse per synchronised rising edge of the strobe.
  assign ent = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

  // State and datapath registers. The synchroniser is only touched by reset,
  // so a clear while the strobe is high cannot manufacture an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      state_q    <= IDLE;
      a_q        <= '0;
      byte_q     <= '0;
      ovf_q      <= 1'b0;
`ifdef LOADER_SKID_EN
      skid_cnt_q <= 2'd0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
`endif
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], load_strobe};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
      state_q    <= state_d;
      a_q        <= a_d;
      byte_q     <= byte_d;
      ovf_q      <= ovf_d;
`ifdef LOADER_SKID_EN
      skid_cnt_q <= skid_cnt_d;
      skid_a_q   <= skid_a_d;
      skid_b_q   <= skid_b_d;
`endif
    end
  end

  // Next-state logic. A is held in a_q until B arrives so op_byte only ever
  // changes to a complete pair and otherwise keeps the last one.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    byte_d  = byte_q;
    ovf_d   = ovf_q;
`ifdef LOADER_SKID_EN
    skid_cnt_d = skid_cnt_q;
    skid_a_d   = skid_a_q;
    skid_b_d   = skid_b_q;
`endif
    if (clear) begin
      state_d = IDLE;
      a_d     = '0;
      byte_d  = '0;
      ovf_d   = 1'b0;
`ifdef LOADER_SKID_EN
      skid_cnt_d = 2'd0;
      skid_a_d   = '0;
      skid_b_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ent) begin
            a_d     = data_in;
            state_d = HAVE_A;
          end
        end
        HAVE_A: begin
          if (ent) begin
            byte_d  = {a_q, data_in};
            state_d = FULL;
          end
        end
        FULL: begin
`ifdef LOADER_SKID_EN
          if (op_if.op_ready) begin
            case (skid_cnt_q)
              2'd1: begin
                // Half-built skid pair becomes the pending A, or completes
                // straight into the output register if B arrives now.
                if (ent) begin
                  byte_d  = {skid_a_q, data_in};
                  state_d = FULL;
                end else begin
                  a_d     = skid_a_q;
                  state_d = HAVE_A;
                end
                skid_cnt_d = 2'd0;
              end
              2'd2: begin
                // Complete skid pair moves up with no valid bubble.
                byte_d  = {skid_a_q, skid_b_q};
                state_d = FULL;
                if (ent) begin
                  skid_a_d   = data_in;
                  skid_cnt_d = 2'd1;
                end else begin
                  skid_cnt_d = 2'd0;
                end
              end
              default: begin
                if (ent) begin
                  a_d     = data_in;
                  state_d = HAVE_A;
                end else begin
                  state_d = IDLE;
                end
              end
            endcase
          end else if (ent) begin
            case (skid_cnt_q)
              2'd0: begin
                skid_a_d   = data_in;
                skid_cnt_d = 2'd1;
              end
              2'd1: begin
                skid_b_d   = data_in;
                skid_cnt_d = 2'd2;
              end
              default: ovf_d = 1'b1;
            endcase
          end
`else
          if (op_if.op_ready) begin
            // Accept and a new entry in the same cycle: the entry starts the next pair.
            if (ent) begin
              a_d     = data_in;
              state_d = HAVE_A;
            end else begin
              state_d = IDLE;
            end
          end else if (ent) begin
            ovf_d = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    op_if.op_valid = (state_q == FULL);
    op_if.op_byte  = byte_q;
    overflow_err   = ovf_q;
`ifdef LOADER_SKID_EN
    have_a = (state_q == HAVE_A) || ((state_q == FULL) && (skid_cnt_q == 2'd1));
`else
    have_a = (state_q == HAVE_A);
`endif
  end

endmodule
